// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int            W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an asynchronous serial line: start, 8 data bits LSB-first,
// optional parity, 1 or 2 stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        byte_done,
    output logic [15:0] tx_count
);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [15:0]          count_q, count_d;
    logic                 bit_end;
    logic                 timer_clear;
    logic                 last_stop;

    // Timer is held at zero outside the serial bit periods so START always gets a full bit.
    assign timer_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    // The bit counter doubles as the stop-bit counter once data bits are done.
    assign last_stop = (state_q == STOP) && bit_end && (bit_idx_q == 3'(STOP_BITS - 1));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d  = fifo_rdata;
                parity_d = (^fifo_rdata) ^ (PARITY_ODD != 0);
                state_d  = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last_stop) begin
                    state_d   = IDLE;
                    bit_idx_d = '0;
                    count_d   = count_q + 16'd1;
                end else if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        tx = IDLE_LEVEL;
        case (state_q)
            START:   tx = START_LEVEL;
            DATA:    tx = shift_q[0];
            PARITY:  tx = parity_q;
            default: tx = IDLE_LEVEL;
        endcase
    end

    assign fifo_rd_en = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign byte_done  = last_stop;
    assign tx_count   = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four configurations run side by side against a frame-level model.
module tb_fifo_uart_tx;

    localparam int NI  = 4;
    localparam int CPB = 4;
    localparam int PE_CFG   [NI] = '{0, 1, 1, 0};
    localparam int ODD_CFG  [NI] = '{0, 0, 1, 0};
    localparam int SB_CFG   [NI] = '{1, 1, 1, 2};
    localparam int HN = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b1;
    logic [3:0]  fifo_empty;
    logic [7:0]  fifo_rdata [NI];
    logic [3:0]  rd_en, tx_w, busy_w, done_w;
    logic [15:0] cnt_w [NI];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bench-side FIFOs ----------------
    logic [7:0] mem [NI][32];
    logic [5:0] wp [NI] = '{6'd0, 6'd0, 6'd0, 6'd0};
    logic [5:0] rp [NI] = '{6'd0, 6'd0, 6'd0, 6'd0};

    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rd_en[g]) begin
                fifo_rdata[g] <= mem[g][rp[g][4:0]];
                rp[g]         <= rp[g] + 6'd1;
            end
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign fifo_empty[g] = (wp[g] == rp[g]);
        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE_CFG[g]),
            .PARITY_ODD  (ODD_CFG[g]),
            .STOP_BITS   (SB_CFG[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_en     (tx_en),
            .fifo_empty(fifo_empty[g]),
            .fifo_rdata(fifo_rdata[g]),
            .fifo_rd_en(rd_en[g]),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .byte_done (done_w[g]),
            .tx_count  (cnt_w[g])
        );
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [NI][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input int g, input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && PE_CFG[g] != 0) return (^b) ^ (ODD_CFG[g] != 0);
        return 1'b1;
    endfunction

    // Model: a transaction is FETCH, LOAD, then the frame bits each CPB cycles long.
    bit          m_act  [NI] = '{0, 0, 0, 0};
    int          m_pos  [NI] = '{0, 0, 0, 0};
    logic [7:0]  m_byte [NI] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [15:0] m_cnt  [NI] = '{16'd0, 16'd0, 16'd0, 16'd0};

    logic [3:0] tx_h [HN];
    logic [3:0] rd_h [HN];
    logic [3:0] done_h [HN];

    always @(negedge clk) begin : cmp
        logic e_tx, e_rd, e_busy, e_done;
        int   last;
        for (int g = 0; g < NI; g++) begin
            last   = 2 + (9 + PE_CFG[g] + SB_CFG[g]) * CPB - 1;
            e_tx   = 1'b1;
            e_rd   = 1'b0;
            e_busy = m_act[g];
            e_done = 1'b0;
            if (m_act[g]) begin
                e_rd   = (m_pos[g] == 0);
                e_done = (m_pos[g] == last);
                if (m_pos[g] >= 2) e_tx = frame_bit(g, m_byte[g], (m_pos[g] - 2) / CPB);
            end
            check($sformatf("tx[%0d]", g), 64'(tx_w[g]), 64'(e_tx));
            check($sformatf("fifo_rd_en[%0d]", g), 64'(rd_en[g]), 64'(e_rd));
            check($sformatf("busy[%0d]", g), 64'(busy_w[g]), 64'(e_busy));
            check($sformatf("byte_done[%0d]", g), 64'(done_w[g]), 64'(e_done));
            check($sformatf("tx_count[%0d]", g), 64'(cnt_w[g]), 64'(m_cnt[g]));
            if (rst) begin
                m_act[g] = 1'b0;
                m_cnt[g] = '0;
            end else if (m_act[g]) begin
                if (m_pos[g] == last) begin
                    m_act[g] = 1'b0;
                    m_cnt[g] = m_cnt[g] + 16'd1;
                end else begin
                    m_pos[g] = m_pos[g] + 1;
                end
            end else if (tx_en && !fifo_empty[g]) begin
                m_act[g] = 1'b1;
                m_pos[g] = 0;
                if (exp_q[g].size() > 0) m_byte[g] = exp_q[g].pop_front();
                else check($sformatf("model_queue[%0d]", g), 64'd0, 64'd1);
            end
        end
        if (cyc < HN) begin
            tx_h[cyc]   = tx_w;
            rd_h[cyc]   = rd_en;
            done_h[cyc] = done_w;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_all(input logic [7:0] b);
        for (int g = 0; g < NI; g++) begin
            mem[g][wp[g][4:0]] = b;
            wp[g] = wp[g] + 6'd1;
            exp_q[g].push_back(b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, t;
        int ones;
        logic [39:0] cap40;
        logic [7:0]  cap8;
        logic [3:0]  acc_rd, acc_tx;

        tick(3);
        check("reset_tx", 64'(tx_w), 64'hF);
        check("reset_busy", 64'(busy_w), 64'h0);
        check("reset_count", 64'(cnt_w[0]), 64'h0);
        rst = 1'b0;
        tick(2);

        // Single frames: 0xA5 plain, 0x07 even/odd parity, 0x5A with two stop bits.
        n = cyc;
        for (int g = 0; g < NI; g++) begin
            logic [7:0] b;
            b = (g == 0) ? 8'hA5 : (g == 3) ? 8'h5A : 8'h07;
            mem[g][wp[g][4:0]] = b;
            wp[g] = wp[g] + 6'd1;
            exp_q[g].push_back(b);
        end
        tick(60);
        for (int i = 0; i < 40; i++) cap40[i] = tx_h[n+3+i][0];
        check("a5_frame", 64'(cap40), 64'hFF0F00F0F0);
        check("a5_pre_start", 64'(tx_h[n+2][0]), 64'h1);
        check("a5_rd_cycle", 64'(rd_h[n+1][0]), 64'h1);
        ones = 0;
        for (int c = n; c < n + 60; c++) ones += int'(rd_h[c][0]);
        check("a5_rd_pulses", 64'(ones), 64'd1);
        ones = 0;
        for (int c = n; c < n + 60; c++) ones += int'(done_h[c][0]);
        check("a5_done_pulses", 64'(ones), 64'd1);
        check("a5_done_cycle", 64'(done_h[n+42][0]), 64'h1);
        check("a5_count", 64'(cnt_w[0]), 64'd1);
        check("par_even_07", 64'(tx_h[n+39][1]), 64'h1);
        check("par_odd_07", 64'(tx_h[n+39][2]), 64'h0);
        check("par_frame_44", 64'(done_h[n+46][1]), 64'h1);
        for (int i = 0; i < 8; i++) cap8[i] = tx_h[n+39+i][3];
        check("stop2_high8", 64'(cap8), 64'hFF);
        check("stop2_bit7", 64'(tx_h[n+38][3]), 64'h0);
        check("stop2_done", 64'(done_h[n+46][3]), 64'h1);

        // Back-to-back frames.
        do_reset();
        n = cyc;
        push_all(8'h01);
        push_all(8'h02);
        push_all(8'h03);
        tick(170);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_start%0d", k), 64'(tx_h[n+3+43*k][0]), 64'h0);
            check($sformatf("b2b_gap%0d", k),
                  64'({tx_h[n+43*k][0], tx_h[n+1+43*k][0], tx_h[n+2+43*k][0]}), 64'h7);
        end
        ones = 0;
        for (int c = n; c < n + 170; c++) ones += int'(done_h[c][0]);
        check("b2b_done_pulses", 64'(ones), 64'd3);
        check("b2b_count", 64'(cnt_w[0]), 64'd3);
        check("b2b_count_stop2", 64'(cnt_w[3]), 64'd3);

        // Transmit disabled with data waiting.
        tx_en = 1'b0;
        n = cyc;
        push_all(8'h3C);
        tick(100);
        acc_rd = '0;
        acc_tx = 4'hF;
        for (int c = n; c < n + 100; c++) begin
            acc_rd = acc_rd | rd_h[c];
            acc_tx = acc_tx & tx_h[c];
        end
        check("dis_no_read", 64'(acc_rd), 64'h0);
        check("dis_tx_idle", 64'(acc_tx), 64'hF);
        t = cyc;
        tx_en = 1'b1;
        tick(60);
        check("en_pre_start", 64'(tx_h[t+2]), 64'hF);
        check("en_start", 64'(tx_h[t+3]), 64'h0);

        // Reset in the middle of data bit 3.
        do_reset();
        n = cyc;
        push_all(8'h11);
        push_all(8'h22);
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_tx", 64'(tx_w), 64'hF);
        check("mid_rst_busy", 64'(busy_w), 64'h0);
        check("mid_rst_count", 64'(cnt_w[0]), 64'd0);
        tick(60);
        check("mid_rst_pre", 64'(tx_h[n+23][0]), 64'h1);
        check("mid_rst_start", 64'(tx_h[n+24][0]), 64'h0);
        for (int i = 0; i < 8; i++) cap8[i] = tx_h[n+24+4*(1+i)+1][0];
        check("mid_rst_next_byte", 64'(cap8), 64'h22);
        check("mid_rst_count_after", 64'(cnt_w[0]), 64'd1);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
